// File: rtl/input_word_fetcher_if.sv
// Bundle of the start/config inputs, the memory read port and the
// byte-stream handshake between the fetcher and its surroundings.
// Byte stream handshake: a byte transfers on a rising edge where out_valid
// and out_ready are both high; once out_valid rises it stays high, with
// out_data stable, until that transfer happens.
interface input_word_fetcher_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] base_adr;
    logic [ADDR_W-1:0] word_count;
    logic [ADDR_W-1:0] memAdr;
    logic              w_r_en;
    logic [DATA_W-1:0] readData;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    // Fetcher side
    modport slave (
        input  start, base_adr, word_count, readData, out_ready,
        output memAdr, w_r_en, out_data, out_valid, busy, done
    );

    // Controller / memory / consumer side
    modport master (
        output start, base_adr, word_count, readData, out_ready,
        input  memAdr, w_r_en, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/input_word_fetcher.sv
// Walks a run of consecutive memory words, latches each one and streams its
// four bytes (least-significant first) over a valid/ready byte interface.
// o_state exposes the FSM state (0 IDLE, 1 FETCH, 2 EMIT, 3 DONE).
module input_word_fetcher #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input_word_fetcher_if.slave bus,
    output logic [1:0]          o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_adr;
    logic [ADDR_W-1:0] r_remain;
    logic [DATA_W-1:0] r_word;
    logic [1:0]        r_byte_idx;
    logic              w_handshake;
    logic              w_last_byte;

    assign w_handshake = (r_state == S_EMIT) && bus.out_ready;
    assign w_last_byte = (r_byte_idx == 2'd3);

    // State register; reset wins over everything, including a run in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection; start is only looked at in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = (bus.word_count != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                w_next_state = S_EMIT;
            end
            S_EMIT: begin
                if (w_handshake && w_last_byte) begin
                    w_next_state = (r_remain != '0) ? S_FETCH : S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath registers: run config capture, word latch, byte/word stepping.
    // Without a handshake in EMIT nothing moves, which keeps memAdr and
    // out_data steady under backpressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_adr      <= '0;
            r_remain   <= '0;
            r_word     <= '0;
            r_byte_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && (bus.word_count != '0)) begin
                        r_adr    <= bus.base_adr;
                        r_remain <= bus.word_count;
                    end
                end
                S_FETCH: begin
                    r_word     <= bus.readData;
                    r_byte_idx <= 2'd0;
                    r_remain   <= r_remain - ADDR_W'(1);
                end
                S_EMIT: begin
                    if (w_handshake) begin
                        if (!w_last_byte) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end else if (r_remain != '0) begin
                            // wraps modulo 2^ADDR_W by construction
                            r_adr <= r_adr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from the current state and datapath registers
    always_comb begin
        bus.memAdr    = r_adr;
        bus.w_r_en    = 1'b0;
        bus.out_data  = r_word[{r_byte_idx, 3'b000} +: 8];
        bus.out_valid = (r_state == S_EMIT);
        bus.busy      = (r_state != S_IDLE);
        bus.done      = (r_state == S_DONE);
        o_state       = r_state;
    end

endmodule
